mor1kx_branch_resolver: RTL and testbench



---
 rtl/mor1kx_branch_resolver_if.sv | 72 +++++++
 rtl/mor1kx_branch_resolver.sv | 194 +++++++++++++++++++
 tb/tb_mor1kx_branch_resolver.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_branch_resolver_if.sv
// Branch resolver bus: decode-side prediction push, execute-side resolution,
// and the predictor-update / misprediction results returned to the core.
// "slave" is the resolver's view; "master" is the pipeline's view.
interface mor1kx_branch_resolver_if #(
   parameter int IDX_BITS             = 10,
   parameter int DEPTH                = 4,
   parameter int OPTION_OPERAND_WIDTH = 32
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // prediction push from decode
   logic                            pred_valid_i;
   logic [IDX_BITS-1:0]             pred_idx_i;
   logic                            pred_taken_i;
   logic [OPTION_OPERAND_WIDTH-1:0] pred_pc_i;
   logic                            pred_ready_o;

   // resolution from execute
   logic                            res_valid_i;
   logic                            res_taken_i;
   logic                            flush_i;

   // results back to the predictor / fetch
   logic                            upd_valid_o;
   logic [IDX_BITS-1:0]             upd_idx_o;
   logic                            upd_taken_o;
   logic                            mispredict_o;
   logic [OPTION_OPERAND_WIDTH-1:0] mispredict_pc_o;
   logic [CNT_W-1:0]                count_o;
   logic                            underflow_o;
   logic [15:0]                     mispredict_cnt_o;

   modport slave (
      input  pred_valid_i,
      input  pred_idx_i,
      input  pred_taken_i,
      input  pred_pc_i,
      output pred_ready_o,
      input  res_valid_i,
      input  res_taken_i,
      input  flush_i,
      output upd_valid_o,
      output upd_idx_o,
      output upd_taken_o,
      output mispredict_o,
      output mispredict_pc_o,
      output count_o,
      output underflow_o,
      output mispredict_cnt_o
   );

   modport master (
      output pred_valid_i,
      output pred_idx_i,
      output pred_taken_i,
      output pred_pc_i,
      input  pred_ready_o,
      output res_valid_i,
      output res_taken_i,
      output flush_i,
      input  upd_valid_o,
      input  upd_idx_o,
      input  upd_taken_o,
      input  mispredict_o,
      input  mispredict_pc_o,
      input  count_o,
      input  underflow_o,
      input  mispredict_cnt_o
   );

endinterface

// File: rtl/mor1kx_branch_resolver.sv
// In-order branch resolver. Conditional-branch predictions are queued at
// decode and popped, oldest first, when execute resolves a branch. Each pop
// produces a predictor training strobe one cycle later; a wrong prediction
// additionally emits a misprediction pulse with the branch PC, bumps a
// saturating counter and discards everything younger still in the queue.
module mor1kx_branch_resolver #(
   parameter int IDX_BITS             = 10,
   parameter int DEPTH                = 4,
   parameter int OPTION_OPERAND_WIDTH = 32
) (
   input logic                     clk,
   input logic                     rst,
   mor1kx_branch_resolver_if.slave br_if
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [15:0]       CNT_MAX = 16'hFFFF;

   // ------------------------------------------------------------------
   // Queue storage and pointers
   // ------------------------------------------------------------------
   logic [IDX_BITS-1:0]             idx_q [DEPTH];
   logic [DEPTH-1:0]                taken_q;
   logic [OPTION_OPERAND_WIDTH-1:0] pc_q  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   logic                            upd_valid_q,      upd_valid_d;
   logic [IDX_BITS-1:0]             upd_idx_q,        upd_idx_d;
   logic                            upd_taken_q,      upd_taken_d;
   logic                            mispredict_q,     mispredict_d;
   logic [OPTION_OPERAND_WIDTH-1:0] mispredict_pc_q,  mispredict_pc_d;
   logic                            underflow_q,      underflow_d;
   logic [15:0]                     mispredict_cnt_q, mispredict_cnt_d;

   // ------------------------------------------------------------------
   // Per-cycle events
   // ------------------------------------------------------------------
   logic                            pred_ready_s;
   logic                            push_s;
   logic                            pop_s;
   logic                            underflow_s;
   logic                            mispred_s;
   logic                            store_s;
   logic [IDX_BITS-1:0]             head_idx_s;
   logic                            head_taken_s;
   logic [OPTION_OPERAND_WIDTH-1:0] head_pc_s;

   // No bypass when full: a pop in the same cycle does not open a slot.
   assign pred_ready_s = (count_q < DEPTH_C) && !rst;

   assign head_idx_s   = idx_q[rd_ptr_q];
   assign head_taken_s = taken_q[rd_ptr_q];
   assign head_pc_s    = pc_q[rd_ptr_q];

   // Decode this cycle's push/pop/underflow/mispredict; a flush masks all of them.
   always_comb begin
      push_s      = 1'b0;
      pop_s       = 1'b0;
      underflow_s = 1'b0;
      mispred_s   = 1'b0;
      if (br_if.flush_i) begin
         push_s      = 1'b0;
         pop_s       = 1'b0;
         underflow_s = 1'b0;
         mispred_s   = 1'b0;
      end else begin
         push_s      = br_if.pred_valid_i && pred_ready_s;
         pop_s       = br_if.res_valid_i && (count_q != CNT_W'(0));
         underflow_s = br_if.res_valid_i && (count_q == CNT_W'(0));
         mispred_s   = pop_s && (head_taken_s != br_if.res_taken_i);
      end
   end

   // A push that coincides with a mispredicting pop is younger and is dropped.
   assign store_s = push_s && !mispred_s;

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH (power of two).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (br_if.flush_i || mispred_s) begin
         wr_ptr_d = PTR_W'(0);
         rd_ptr_d = PTR_W'(0);
         count_d  = CNT_W'(0);
      end else begin
         if (store_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({store_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Result next-state: training strobe on every pop, mispredict info on wrong direction.
   always_comb begin
      upd_valid_d      = pop_s;
      upd_idx_d        = upd_idx_q;
      upd_taken_d      = upd_taken_q;
      mispredict_d     = mispred_s;
      mispredict_pc_d  = mispredict_pc_q;
      underflow_d      = underflow_s;
      mispredict_cnt_d = mispredict_cnt_q;
      if (pop_s) begin
         upd_idx_d   = head_idx_s;
         upd_taken_d = br_if.res_taken_i;
      end else begin
         upd_idx_d   = upd_idx_q;
         upd_taken_d = upd_taken_q;
      end
      if (mispred_s) begin
         mispredict_pc_d = head_pc_s;
         if (mispredict_cnt_q != CNT_MAX) begin
            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
         end else begin
            mispredict_cnt_d = mispredict_cnt_q;
         end
      end else begin
         mispredict_pc_d  = mispredict_pc_q;
         mispredict_cnt_d = mispredict_cnt_q;
      end
   end

   // Queue entry storage: written at the write pointer on an accepted push.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx_q[i] <= {IDX_BITS{1'b0}};
            pc_q[i]  <= {OPTION_OPERAND_WIDTH{1'b0}};
         end
         taken_q <= {DEPTH{1'b0}};
      end else if (store_s) begin
         idx_q[wr_ptr_q]   <= br_if.pred_idx_i;
         taken_q[wr_ptr_q] <= br_if.pred_taken_i;
         pc_q[wr_ptr_q]    <= br_if.pred_pc_i;
      end
   end

   // Control and result registers; reset clears queue state and every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q         <= PTR_W'(0);
         rd_ptr_q         <= PTR_W'(0);
         count_q          <= CNT_W'(0);
         upd_valid_q      <= 1'b0;
         upd_idx_q        <= {IDX_BITS{1'b0}};
         upd_taken_q      <= 1'b0;
         mispredict_q     <= 1'b0;
         mispredict_pc_q  <= {OPTION_OPERAND_WIDTH{1'b0}};
         underflow_q      <= 1'b0;
         mispredict_cnt_q <= 16'd0;
      end else begin
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         upd_valid_q      <= upd_valid_d;
         upd_idx_q        <= upd_idx_d;
         upd_taken_q      <= upd_taken_d;
         mispredict_q     <= mispredict_d;
         mispredict_pc_q  <= mispredict_pc_d;
         underflow_q      <= underflow_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign br_if.pred_ready_o     = pred_ready_s;
   assign br_if.upd_valid_o      = upd_valid_q;
   assign br_if.upd_idx_o        = upd_idx_q;
   assign br_if.upd_taken_o      = upd_taken_q;
   assign br_if.mispredict_o     = mispredict_q;
   assign br_if.mispredict_pc_o  = mispredict_pc_q;
   assign br_if.count_o          = count_q;
   assign br_if.underflow_o      = underflow_q;
   assign br_if.mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Directed bench for mor1kx_branch_resolver (default parameters: 10-bit
// index, 4 entries, 32-bit PC). Inputs change #1 after the rising edge,
// registered outputs are checked at the same point.
module tb_mor1kx_branch_resolver;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mor1kx_branch_resolver_if #(
      .IDX_BITS(10), .DEPTH(4), .OPTION_OPERAND_WIDTH(32)
   ) br_if ();

   mor1kx_branch_resolver #(
      .IDX_BITS(10), .DEPTH(4), .OPTION_OPERAND_WIDTH(32)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .br_if (br_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [9:0] idx, input logic tk, input logic [31:0] pc);
      br_if.pred_valid_i = 1'b1;
      br_if.pred_idx_i   = idx;
      br_if.pred_taken_i = tk;
      br_if.pred_pc_i    = pc;
      tick();
      br_if.pred_valid_i = 1'b0;
   endtask

   task automatic resolve(input logic tk);
      br_if.res_valid_i = 1'b1;
      br_if.res_taken_i = tk;
      tick();
      br_if.res_valid_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_count"},    32'(br_if.count_o),          32'd0);
      check({tag, "_updv"},     32'(br_if.upd_valid_o),      32'd0);
      check({tag, "_updidx"},   32'(br_if.upd_idx_o),        32'd0);
      check({tag, "_updtk"},    32'(br_if.upd_taken_o),      32'd0);
      check({tag, "_misp"},     32'(br_if.mispredict_o),     32'd0);
      check({tag, "_misppc"},   32'(br_if.mispredict_pc_o),  32'd0);
      check({tag, "_undf"},     32'(br_if.underflow_o),      32'd0);
      check({tag, "_mispcnt"},  32'(br_if.mispredict_cnt_o), 32'd0);
   endtask

   initial begin
      logic [9:0]  order_exp [3];
      logic [15:0] sat_exp   [3];
      checks = 0;
      errors = 0;
      order_exp = '{10'd13, 10'd14, 10'd16};
      sat_exp   = '{16'hFFFE, 16'hFFFF, 16'hFFFF};

      rst                = 1'b1;
      br_if.pred_valid_i = 1'b0;
      br_if.pred_idx_i   = 10'd0;
      br_if.pred_taken_i = 1'b0;
      br_if.pred_pc_i    = 32'd0;
      br_if.res_valid_i  = 1'b0;
      br_if.res_taken_i  = 1'b0;
      br_if.flush_i      = 1'b0;

      // reset state
      tick();
      tick();
      check_all_zero("rst");
      check("rst_ready", 32'(br_if.pred_ready_o), 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(br_if.pred_ready_o), 32'd1);

      // four correct predictions, drained in order
      for (int i = 1; i <= 4; i++) push_one(10'(i), 1'b1, 32'h200 + 32'(i));
      check("fill4_count", 32'(br_if.count_o), 32'd4);
      check("fill4_ready", 32'(br_if.pred_ready_o), 32'd0);
      check("fill4_updv", 32'(br_if.upd_valid_o), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         resolve(1'b1);
         check("drain_updv",  32'(br_if.upd_valid_o),  32'd1);
         check("drain_idx",   32'(br_if.upd_idx_o),    32'(i));
         check("drain_tk",    32'(br_if.upd_taken_o),  32'd1);
         check("drain_misp",  32'(br_if.mispredict_o), 32'd0);
         check("drain_count", 32'(br_if.count_o),      32'(4 - i));
      end
      tick();
      check("drain_updv_idle", 32'(br_if.upd_valid_o), 32'd0);

      // full queue: same-cycle pop does not admit the push
      for (int i = 11; i <= 14; i++) push_one(10'(i), 1'b1, 32'h300 + 32'(i));
      br_if.pred_valid_i = 1'b1;
      br_if.pred_idx_i   = 10'd15;
      br_if.pred_taken_i = 1'b1;
      br_if.res_valid_i  = 1'b1;
      br_if.res_taken_i  = 1'b1;
      #1;
      check("full_ready", 32'(br_if.pred_ready_o), 32'd0);
      tick();
      check("full_count", 32'(br_if.count_o),     32'd3);
      check("full_updv",  32'(br_if.upd_valid_o), 32'd1);
      check("full_idx",   32'(br_if.upd_idx_o),   32'd11);
      // simultaneous push and pop at count 3
      check("pp_ready", 32'(br_if.pred_ready_o), 32'd1);
      br_if.pred_idx_i = 10'd16;
      tick();
      br_if.pred_valid_i = 1'b0;
      br_if.res_valid_i  = 1'b0;
      check("pp_count", 32'(br_if.count_o),   32'd3);
      check("pp_idx",   32'(br_if.upd_idx_o), 32'd12);
      for (int k = 0; k < 3; k++) begin
         resolve(1'b1);
         check("order_idx",   32'(br_if.upd_idx_o), 32'(order_exp[k]));
         check("order_count", 32'(br_if.count_o),   32'(2 - k));
      end

      // mispredict discards younger entry and same-cycle push
      push_one(10'd5, 1'b0, 32'h100);
      push_one(10'd6, 1'b1, 32'h104);
      br_if.pred_valid_i = 1'b1;
      br_if.pred_idx_i   = 10'd7;
      br_if.pred_taken_i = 1'b1;
      br_if.pred_pc_i    = 32'h108;
      br_if.res_valid_i  = 1'b1;
      br_if.res_taken_i  = 1'b1;
      tick();
      br_if.pred_valid_i = 1'b0;
      br_if.res_valid_i  = 1'b0;
      check("mp_updv",   32'(br_if.upd_valid_o),      32'd1);
      check("mp_idx",    32'(br_if.upd_idx_o),        32'd5);
      check("mp_tk",     32'(br_if.upd_taken_o),      32'd1);
      check("mp_pulse",  32'(br_if.mispredict_o),     32'd1);
      check("mp_pc",     32'(br_if.mispredict_pc_o),  32'h100);
      check("mp_count",  32'(br_if.count_o),          32'd0);
      check("mp_cnt",    32'(br_if.mispredict_cnt_o), 32'd1);
      tick();
      check("mp_pulse_end", 32'(br_if.mispredict_o),    32'd0);
      check("mp_updv_end",  32'(br_if.upd_valid_o),     32'd0);
      check("mp_pc_hold",   32'(br_if.mispredict_pc_o), 32'h100);
      check("mp_count_end", 32'(br_if.count_o),         32'd0);

      // underflow with same-cycle push accepted
      br_if.pred_valid_i = 1'b1;
      br_if.pred_idx_i   = 10'd8;
      br_if.pred_taken_i = 1'b0;
      br_if.pred_pc_i    = 32'h300;
      br_if.res_valid_i  = 1'b1;
      br_if.res_taken_i  = 1'b0;
      tick();
      br_if.pred_valid_i = 1'b0;
      br_if.res_valid_i  = 1'b0;
      check("uf_pulse", 32'(br_if.underflow_o),  32'd1);
      check("uf_updv",  32'(br_if.upd_valid_o),  32'd0);
      check("uf_misp",  32'(br_if.mispredict_o), 32'd0);
      check("uf_count", 32'(br_if.count_o),      32'd1);
      resolve(1'b0);
      check("uf2_pulse", 32'(br_if.underflow_o),  32'd0);
      check("uf2_updv",  32'(br_if.upd_valid_o),  32'd1);
      check("uf2_idx",   32'(br_if.upd_idx_o),    32'd8);
      check("uf2_tk",    32'(br_if.upd_taken_o),  32'd0);
      check("uf2_misp",  32'(br_if.mispredict_o), 32'd0);
      check("uf2_count", 32'(br_if.count_o),      32'd0);
      resolve(1'b1);
      check("uf3_pulse", 32'(br_if.underflow_o),      32'd1);
      check("uf3_updv",  32'(br_if.upd_valid_o),      32'd0);
      check("uf3_count", 32'(br_if.count_o),          32'd0);
      check("uf3_cnt",   32'(br_if.mispredict_cnt_o), 32'd1);

      // flush beats resolution and push
      push_one(10'd20, 1'b1, 32'h400);
      push_one(10'd21, 1'b0, 32'h404);
      br_if.flush_i      = 1'b1;
      br_if.res_valid_i  = 1'b1;
      br_if.res_taken_i  = 1'b0;
      br_if.pred_valid_i = 1'b1;
      br_if.pred_idx_i   = 10'd22;
      tick();
      br_if.flush_i      = 1'b0;
      br_if.res_valid_i  = 1'b0;
      br_if.pred_valid_i = 1'b0;
      check("fl_count", 32'(br_if.count_o),      32'd0);
      check("fl_updv",  32'(br_if.upd_valid_o),  32'd0);
      check("fl_misp",  32'(br_if.mispredict_o), 32'd0);
      check("fl_undf",  32'(br_if.underflow_o),  32'd0);
      tick();
      check("fl_cnt",   32'(br_if.mispredict_cnt_o), 32'd1);
      check("fl_pc",    32'(br_if.mispredict_pc_o),  32'h100);
      push_one(10'd23, 1'b1, 32'h408);
      resolve(1'b1);
      check("fl_next_idx",   32'(br_if.upd_idx_o),    32'd23);
      check("fl_next_misp",  32'(br_if.mispredict_o), 32'd0);
      check("fl_next_count", 32'(br_if.count_o),      32'd0);

      // counter saturation: preload near the top, then real mispredicts
      force dut.mispredict_cnt_q = 16'hFFFD;
      tick();
      release dut.mispredict_cnt_q;
      check("sat_preload", 32'(br_if.mispredict_cnt_o), 32'h0000FFFD);
      for (int k = 0; k < 3; k++) begin
         push_one(10'(40 + k), 1'b0, 32'h500 + 32'(k));
         resolve(1'b1);
         check("sat_pulse", 32'(br_if.mispredict_o),     32'd1);
         check("sat_pc",    32'(br_if.mispredict_pc_o),  32'h500 + 32'(k));
         check("sat_cnt",   32'(br_if.mispredict_cnt_o), 32'(sat_exp[k]));
      end

      // reset mid-operation with a pending mispredicting resolution
      push_one(10'd50, 1'b0, 32'h600);
      push_one(10'd51, 1'b1, 32'h604);
      rst                = 1'b1;
      br_if.res_valid_i  = 1'b1;
      br_if.res_taken_i  = 1'b1;
      br_if.pred_valid_i = 1'b1;
      br_if.pred_idx_i   = 10'd52;
      tick();
      check_all_zero("mrst");
      check("mrst_ready", 32'(br_if.pred_ready_o), 32'd0);
      rst                = 1'b0;
      br_if.pred_valid_i = 1'b0;
      tick();
      br_if.res_valid_i  = 1'b0;
      check("post_rst_updv",  32'(br_if.upd_valid_o),      32'd0);
      check("post_rst_misp",  32'(br_if.mispredict_o),     32'd0);
      check("post_rst_undf",  32'(br_if.underflow_o),      32'd1);
      check("post_rst_count", 32'(br_if.count_o),          32'd0);
      check("post_rst_cnt",   32'(br_if.mispredict_cnt_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
